// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Memory read port, redirect and decode handshake of the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;
  logic                  instr_valid_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  instr_ready_i;

  modport master (
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output mem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Sequential instruction prefetcher with redirect flush.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  wire logic    clk,
  input  wire logic    reset_i,
  fetch_unit_if.master bus
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [FIFO_DEPTH];

  logic           req;
  logic           push;
  logic           pop;
  logic           valid;
  logic [CNT_W:0] credit_used;

  // Buffered entries plus the outstanding read form the credit budget.
  assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign req         = !reset_i && !bus.redirect_i && (credit_used < DEPTH_C);
  assign push        = inflight_q && !bus.redirect_i;
  assign valid       = (count_q != '0);
  assign pop         = valid && bus.instr_ready_i;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = req;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_pc_i;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (req) begin
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(1);
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= bus.mem_rdata_i;
      pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign bus.mem_req_o     = req;
  assign bus.mem_addr_o    = fetch_pc_q;
  assign bus.instr_valid_o = valid;
  assign bus.instr_o       = data_q[rd_ptr_q];
  assign bus.instr_pc_o    = pc_q[rd_ptr_q];

  a_no_overflow : assert property (@(posedge clk) disable iff (reset_i)
    !(push && (count_q == FULL_C)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed bench for fetch_unit with a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam int          AW    = 16;
  localparam int          DW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] SALT  = 16'hA5A5;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

  fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut_a (
    .clk(clk), .reset_i(rst), .bus(ifa)
  );

  fetch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RESET_PC(16'hFFFE)
  ) dut_b (
    .clk(clk), .reset_i(rst), .bus(ifb)
  );

  // One-cycle synchronous memory: rdata = addr ^ SALT.
  always @(posedge clk) begin
    if (ifa.mem_req_o) ifa.mem_rdata_i <= ifa.mem_addr_o ^ SALT;
    if (ifb.mem_req_o) ifb.mem_rdata_i <= ifb.mem_addr_o ^ SALT;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model for dut_a: a queue of fetched entries plus one outstanding read.
  ent_t          m_q[$];
  logic [AW-1:0] m_pc;
  bit            m_infl;
  logic [AW-1:0] m_infl_pc;

  function automatic bit model_req();
    return !ifa.redirect_i && ((m_q.size() + int'(m_infl)) < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_pc      = 16'h0000;
      m_infl    = 1'b0;
      m_infl_pc = '0;
    end else if (ifa.redirect_i) begin
      m_q.delete();
      m_pc   = ifa.redirect_pc_i;
      m_infl = 1'b0;
    end else begin
      bit r;
      r = model_req();
      if (ifa.instr_ready_i && m_q.size() != 0) void'(m_q.pop_front());
      if (m_infl) m_q.push_back('{pc: m_infl_pc, data: m_infl_pc ^ SALT});
      if (r) begin
        m_infl_pc = m_pc;
        m_pc      = m_pc + 16'd1;
        m_infl    = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("reset req",   32'(ifa.mem_req_o),     0);
      chk("reset valid", 32'(ifa.instr_valid_o), 0);
      chk("reset instr", 32'(ifa.instr_o),       0);
      chk("reset pc",    32'(ifa.instr_pc_o),    0);
      chk("reset addr",  32'(ifa.mem_addr_o),    0);
    end else begin
      chk("model req",   32'(ifa.mem_req_o),     32'(model_req()));
      chk("model addr",  32'(ifa.mem_addr_o),    32'(m_pc));
      chk("model valid", 32'(ifa.instr_valid_o), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("model instr", 32'(ifa.instr_o),    32'(m_q[0].data));
        chk("model pc",    32'(ifa.instr_pc_o), 32'(m_q[0].pc));
      end
    end
  end

  // Log of dut_b traffic for the wrap-around check.
  logic [AW-1:0] b_req[$];
  logic [AW-1:0] b_pc[$];
  logic [DW-1:0] b_dat[$];
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      b_req.delete();
      b_pc.delete();
      b_dat.delete();
    end else begin
      if (ifb.mem_req_o)     b_req.push_back(ifb.mem_addr_o);
      if (ifb.instr_valid_o) begin
        b_pc.push_back(ifb.instr_pc_o);
        b_dat.push_back(ifb.instr_o);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    rst               = 1'b1;
    ifa.instr_ready_i = rdy;
    ifa.redirect_i    = 1'b0;
    ifa.redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] wrap_exp[4];
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    ifb.redirect_i    = 1'b0;
    ifb.redirect_pc_i = '0;
    ifb.instr_ready_i = 1'b1;

    // Cold start, streaming with ready held high.
    do_reset(1'b1);
    #3;
    chk("cold c0 req",   32'(ifa.mem_req_o),     1);
    chk("cold c0 addr",  32'(ifa.mem_addr_o),    0);
    chk("cold c0 valid", 32'(ifa.instr_valid_o), 0);
    next_cycle(); #3;
    chk("cold c1 addr",  32'(ifa.mem_addr_o),    1);
    chk("cold c1 valid", 32'(ifa.instr_valid_o), 0);
    for (int k = 2; k < 9; k++) begin
      next_cycle(); #3;
      chk("cold valid", 32'(ifa.instr_valid_o), 1);
      chk("cold pc",    32'(ifa.instr_pc_o),    32'(k - 2));
      chk("cold instr", 32'(ifa.instr_o),       32'(16'(k - 2) ^ SALT));
    end

    // Wrap on the second instance (RESET_PC = FFFE).
    if (b_req.size() < 4 || b_pc.size() < 4) begin
      chk("wrap log size", 32'(b_pc.size()), 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk("wrap req addr", 32'(b_req[i]), 32'(wrap_exp[i]));
        chk("wrap out pc",   32'(b_pc[i]),  32'(wrap_exp[i]));
        chk("wrap out data", 32'(b_dat[i]), 32'(wrap_exp[i] ^ SALT));
      end
    end

    // Backpressure: exactly DEPTH requests, then stall with a stable head.
    do_reset(1'b0);
    #3;
    chk("bp req0", 32'(ifa.mem_req_o), 1);
    for (int k = 1; k < 4; k++) begin
      next_cycle(); #3;
      chk("bp req",  32'(ifa.mem_req_o),  1);
      chk("bp addr", 32'(ifa.mem_addr_o), 32'(k));
    end
    for (int k = 4; k < 10; k++) begin
      next_cycle(); #3;
      chk("bp stall req", 32'(ifa.mem_req_o),     0);
      chk("bp valid",     32'(ifa.instr_valid_o), 1);
      chk("bp head pc",   32'(ifa.instr_pc_o),    0);
    end
    next_cycle(); ifa.instr_ready_i = 1'b1; #3;
    chk("bp pop0 pc",  32'(ifa.instr_pc_o), 0);
    chk("bp pop0 req", 32'(ifa.mem_req_o),  0);
    next_cycle(); #3;
    chk("bp pop1 pc",  32'(ifa.instr_pc_o), 1);
    chk("bp req4",     32'(ifa.mem_req_o),  1);
    chk("bp addr4",    32'(ifa.mem_addr_o), 4);
    next_cycle(); #3;
    chk("bp pop2 pc",  32'(ifa.instr_pc_o), 2);
    next_cycle(); #3;
    chk("bp pop3 pc",  32'(ifa.instr_pc_o), 3);

    // Redirect while streaming, head pc = 5.
    do_reset(1'b1);
    repeat (7) next_cycle();
    ifa.redirect_i = 1'b1; ifa.redirect_pc_i = 16'h0100; #3;
    chk("rd req N",   32'(ifa.mem_req_o),  0);
    chk("rd head N",  32'(ifa.instr_pc_o), 5);
    next_cycle(); ifa.redirect_i = 1'b0; #3;
    chk("rd valid N+1", 32'(ifa.instr_valid_o), 0);
    chk("rd req N+1",   32'(ifa.mem_req_o),     1);
    chk("rd addr N+1",  32'(ifa.mem_addr_o),    32'h0100);
    next_cycle(); #3;
    chk("rd valid N+2", 32'(ifa.instr_valid_o), 0);
    next_cycle(); #3;
    chk("rd valid N+3", 32'(ifa.instr_valid_o), 1);
    chk("rd pc N+3",    32'(ifa.instr_pc_o),    32'h0100);
    chk("rd instr N+3", 32'(ifa.instr_o),       32'hA4A5);
    repeat (4) next_cycle();

    // Redirect with a full FIFO and ready low, then back-to-back redirects.
    do_reset(1'b0);
    repeat (6) next_cycle();
    ifa.redirect_i = 1'b1; ifa.redirect_pc_i = 16'h0040; #3;
    chk("rf req N",  32'(ifa.mem_req_o),  0);
    chk("rf head N", 32'(ifa.instr_pc_o), 0);
    next_cycle(); ifa.redirect_i = 1'b0; #3;
    chk("rf valid N+1", 32'(ifa.instr_valid_o), 0);
    chk("rf addr N+1",  32'(ifa.mem_addr_o),    32'h0040);
    next_cycle(); #3;
    chk("rf addr N+2",  32'(ifa.mem_addr_o),    32'h0041);
    next_cycle(); #3;
    chk("rf pc N+3",    32'(ifa.instr_pc_o),    32'h0040);
    chk("rf instr N+3", 32'(ifa.instr_o),       32'hA5E5);
    next_cycle(); ifa.instr_ready_i = 1'b1; #3;
    chk("rf pop pc0", 32'(ifa.instr_pc_o), 32'h0040);
    next_cycle(); #3;
    chk("rf pop pc1", 32'(ifa.instr_pc_o), 32'h0041);
    next_cycle(); ifa.redirect_i = 1'b1; ifa.redirect_pc_i = 16'h0200; #3;
    chk("b2b req 1", 32'(ifa.mem_req_o), 0);
    next_cycle(); ifa.redirect_pc_i = 16'h0300; #3;
    chk("b2b req 2",   32'(ifa.mem_req_o),     0);
    chk("b2b valid 2", 32'(ifa.instr_valid_o), 0);
    next_cycle(); ifa.redirect_i = 1'b0; #3;
    chk("b2b addr", 32'(ifa.mem_addr_o), 32'h0300);
    chk("b2b req",  32'(ifa.mem_req_o),  1);
    next_cycle(); next_cycle(); #3;
    chk("b2b pc",    32'(ifa.instr_pc_o), 32'h0300);
    chk("b2b instr", 32'(ifa.instr_o),    32'hA6A5);

    // Asynchronous reset between clock edges.
    do_reset(1'b1);
    repeat (5) next_cycle();
    #1;
    chk("ar pre valid", 32'(ifa.instr_valid_o), 1);
    chk("ar pre req",   32'(ifa.mem_req_o),     1);
    #1 rst = 1'b1;
    #1;
    chk("ar valid", 32'(ifa.instr_valid_o), 0);
    chk("ar req",   32'(ifa.mem_req_o),     0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; #3;
    chk("ar c0 req",   32'(ifa.mem_req_o),     1);
    chk("ar c0 addr",  32'(ifa.mem_addr_o),    0);
    chk("ar c0 valid", 32'(ifa.instr_valid_o), 0);
    next_cycle(); #3;
    chk("ar c1 valid", 32'(ifa.instr_valid_o), 0);
    next_cycle(); #3;
    chk("ar c2 pc",    32'(ifa.instr_pc_o), 0);
    chk("ar c2 instr", 32'(ifa.instr_o),    32'hA5A5);
    repeat (3) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage between the instruction memory port and the processor decode stage.
- Issues sequential word-address reads to a fixed 1-cycle-latency synchronous memory.
- Buffers the returned words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) input that flushes all buffered and in-flight fetches.

Parameters:
ADDR_WIDTH, 16, width of word address / PC
DATA_WIDTH, 16, instruction word width
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset_i  in  1  asynchronous, active-high reset
mem_req_o  out  1  read request this cycle
mem_addr_o  out  ADDR_WIDTH  read word address; meaningful when mem_req_o=1
mem_rdata_i  in  DATA_WIDTH  read data; valid in the cycle after the request
redirect_i  in  1  flush and restart fetch at redirect_pc_i
redirect_pc_i  in  ADDR_WIDTH  new fetch PC
instr_valid_o  out  1  FIFO head valid
instr_o  out  DATA_WIDTH  FIFO head instruction
instr_pc_o  out  ADDR_WIDTH  PC of FIFO head
instr_ready_i  in  1  decode accepts head this cycle

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, FIFO empty, inflight=0, mem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, mem_addr_o=RESET_PC. Reset mid-operation discards everything.
- State: fetch_pc register, inflight flag (request issued last cycle), inflight_pc register, FIFO of {pc, data}, count 0..FIFO_DEPTH.
- Request (combinational from registered state plus redirect_i):
  - mem_req_o = !redirect_i && (count + inflight < FIFO_DEPTH).
  - mem_addr_o = fetch_pc.
  - On request: fetch_pc <= fetch_pc + 1 (modulo 2^ADDR_WIDTH), inflight <= 1, inflight_pc <= fetch_pc.
  - Otherwise: inflight <= 0.
- Response: when inflight=1 and redirect_i=0, push {inflight_pc, mem_rdata_i} at the end of the cycle. The credit rule guarantees the FIFO never overflows; pushing into a full FIFO is a design error (assertion).
- Output:
  - instr_valid_o = count != 0.
  - instr_o and instr_pc_o show the FIFO head. Both are combinational from FIFO storage and are stable while valid=1 and ready=0.
  - Pop when instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Redirect (cycle N, redirect_i=1):
  - mem_req_o forced 0 in cycle N.
  - A handshake completing in cycle N counts as a transfer; decode owns that decision.
  - At the end of cycle N: FIFO cleared (count=0), the in-flight response arriving in N is dropped, fetch_pc <= redirect_pc_i, inflight <= 0.
  - N+1: instr_valid_o=0; mem_req_o=1 with addr=redirect_pc_i.
  - N+3: earliest instr_valid_o with instr_pc_o=redirect_pc_i.
  - No instruction fetched before the redirect ever appears after cycle N.
  - Back-to-back redirects: the last one wins; each cycle repeats the rules above.
- Latency and throughput:
  - Request in cycle t -> data pushed at the end of t+1 -> visible at instr_* in t+2.
  - With instr_ready_i held 1, the block sustains one instruction per cycle after fill.
  - With ready=0, exactly FIFO_DEPTH requests are outstanding or buffered before mem_req_o stops.
- PC wrap: 2^ADDR_WIDTH-1 is followed by 0, with no special handling.
- No combinational path from instr_ready_i to mem_req_o or mem_addr_o. mem_req_o depends combinationally only on redirect_i and registered state.

Test Plan:
- Cold start: RESET_PC=0, memory model returns rdata=addr^16'hA5A5, ready=1, release reset -> mem_req_o=1 addr 0 in the first cycle. instr_valid_o two cycles later with instr=A5A5, pc=0. Then pcs 1,2,3,... on consecutive cycles with no bubbles.
- Backpressure: ready=0 from start -> exactly 4 requests (addr 0..3), then mem_req_o=0 indefinitely, count=4, head pc=0 stable. Raise ready=1 -> pcs 0,1,2,3 popped in order. A request for addr 4 is issued the cycle after the first pop.
- Redirect while streaming: at cycle N with head pc=5, redirect_i=1, redirect_pc_i=16'h0100 -> mem_req_o=0 in N. In N+1, req addr 0x0100 and instr_valid_o=0. At N+3, instr_pc_o=0x0100, instr=0x0100^A5A5. No pc 6..9 ever observed.
- Redirect with a full FIFO and ready=0: fill 4 entries, redirect to 0x0040 -> count=0 next cycle. The following fetches are 0x0040 onward only.
- Wrap: RESET_PC=16'hFFFE, ready=1 -> request addresses FFFE, FFFF, 0000, 0001; output pcs are in the same order.
- Async reset mid-stream: assert reset_i between clock edges while valid=1 and req=1 -> instr_valid_o and mem_req_o go 0 immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC and no stale entries are presented.
